// File: rtl/r4w_lora_frame_seq.sv
// r4w_lora_frame_seq
//   Upstream sequencer for the LoRa chirp generator. A start pulse emits one
//   frame as chirp commands: preamble upchirps, two sync-word upchirps, two
//   full downchirps plus one quarter downchirp (SFD), then one modulated
//   upchirp per payload symbol pulled from an AXI-Stream. Each command is
//   issued only after the generator reports completion of the previous one.
//
//   Ports
//     clk, rst                 clock, synchronous active-high reset
//     cfg_sf/pre_len/sync_word frame configuration, latched on start
//     start, abort             frame start / abort pulses
//     s_axis_*                 payload symbol stream (tready only while a
//                              payload command is pending)
//     chirp_start/up/quarter/symbol/sf
//                              command to generator; fields hold between strobes
//     chirp_done               generator completion pulse
//     busy, frame_done         frame status
//     underflow                sticky payload-starvation flag, cleared on start
`timescale 1ns/1ps
module r4w_lora_frame_seq #(
  parameter int SYM_WIDTH = 12,
  parameter int PRE_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           cfg_sf,
  input  logic [PRE_WIDTH-1:0] cfg_pre_len,
  input  logic [7:0]           cfg_sync_word,
  input  logic                 start,
  input  logic                 abort,
  input  logic [SYM_WIDTH-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  output logic                 chirp_start,
  output logic                 chirp_up,
  output logic                 chirp_quarter,
  output logic [SYM_WIDTH-1:0] chirp_symbol,
  output logic [3:0]           chirp_sf,
  input  logic                 chirp_done,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 underflow
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_LOAD,
    ST_PRE_I, ST_PRE_W,
    ST_SYNC1_I, ST_SYNC1_W,
    ST_SYNC2_I, ST_SYNC2_W,
    ST_SFD1_I, ST_SFD1_W,
    ST_SFD2_I, ST_SFD2_W,
    ST_SFDQ_I, ST_SFDQ_W,
    ST_PAY_I, ST_PAY_W
  } state_t;

  state_t state, state_nxt;

  logic [3:0]           sf_q;
  logic [PRE_WIDTH-1:0] pre_q;
  logic [7:0]           sync_q;
  logic [PRE_WIDTH-1:0] pre_cnt;
  logic [PRE_WIDTH-1:0] pre_last_idx;
  logic                 pre_last;
  logic                 last_q;
  logic                 up_q;
  logic                 quarter_q;
  logic [SYM_WIDTH-1:0] sym_q;
  logic [SYM_WIDTH-1:0] sync1_sym;
  logic [SYM_WIDTH-1:0] sync2_sym;

  logic                 strobe;
  logic                 cur_up;
  logic                 cur_quarter;
  logic [SYM_WIDTH-1:0] cur_sym;
  logic                 tready;

  // Keep only the low sf bits of a symbol.
  function automatic logic [SYM_WIDTH-1:0] sf_mask(input logic [SYM_WIDTH-1:0] v,
                                                   input logic [3:0] sf);
    logic [SYM_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < SYM_WIDTH; i++) begin
      if (i < int'(sf)) m[i] = 1'b1;
    end
    return v & m;
  endfunction

  // A preamble length of 0 behaves as 1, so the last index is 0 in both cases.
  assign pre_last_idx = (pre_q == '0) ? '0 : pre_q - 1'b1;
  assign pre_last     = (pre_cnt == pre_last_idx);
  assign sync1_sym    = sf_mask(SYM_WIDTH'({sync_q[7:4], 3'b000}), sf_q);
  assign sync2_sym    = sf_mask(SYM_WIDTH'({sync_q[3:0], 3'b000}), sf_q);

  // Stage 0: next-state and command decode
  always_comb begin
    state_nxt   = state;
    strobe      = 1'b0;
    cur_up      = 1'b1;
    cur_quarter = 1'b0;
    cur_sym     = '0;
    tready      = 1'b0;
    case (state)
      ST_IDLE:    if (start) state_nxt = ST_LOAD;
      ST_LOAD:    state_nxt = ST_PRE_I;
      ST_PRE_I:   begin strobe = 1'b1; state_nxt = ST_PRE_W; end
      ST_PRE_W:   if (chirp_done) state_nxt = pre_last ? ST_SYNC1_I : ST_PRE_I;
      ST_SYNC1_I: begin strobe = 1'b1; cur_sym = sync1_sym; state_nxt = ST_SYNC1_W; end
      ST_SYNC1_W: if (chirp_done) state_nxt = ST_SYNC2_I;
      ST_SYNC2_I: begin strobe = 1'b1; cur_sym = sync2_sym; state_nxt = ST_SYNC2_W; end
      ST_SYNC2_W: if (chirp_done) state_nxt = ST_SFD1_I;
      ST_SFD1_I:  begin strobe = 1'b1; cur_up = 1'b0; state_nxt = ST_SFD1_W; end
      ST_SFD1_W:  if (chirp_done) state_nxt = ST_SFD2_I;
      ST_SFD2_I:  begin strobe = 1'b1; cur_up = 1'b0; state_nxt = ST_SFD2_W; end
      ST_SFD2_W:  if (chirp_done) state_nxt = ST_SFDQ_I;
      ST_SFDQ_I:  begin
        strobe      = 1'b1;
        cur_up      = 1'b0;
        cur_quarter = 1'b1;
        state_nxt   = ST_SFDQ_W;
      end
      ST_SFDQ_W:  if (chirp_done) state_nxt = ST_PAY_I;
      ST_PAY_I:   begin
        tready  = 1'b1;
        cur_sym = sf_mask(s_axis_tdata, sf_q);
        if (s_axis_tvalid) begin
          strobe    = 1'b1;
          state_nxt = ST_PAY_W;
        end
      end
      ST_PAY_W:   if (chirp_done) state_nxt = last_q ? ST_IDLE : ST_PAY_I;
      default:    state_nxt = ST_IDLE;
    endcase
    // Abort wins over everything, including a handshake in the same cycle.
    if (abort) begin
      state_nxt = ST_IDLE;
      strobe    = 1'b0;
      tready    = 1'b0;
    end
  end

  // Stage 1: state, latched configuration and held command fields
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      sf_q       <= '0;
      pre_q      <= '0;
      sync_q     <= '0;
      pre_cnt    <= '0;
      last_q     <= 1'b0;
      up_q       <= 1'b0;
      quarter_q  <= 1'b0;
      sym_q      <= '0;
      frame_done <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= (state == ST_PAY_W) && chirp_done && last_q && !abort;
      if ((state == ST_IDLE) && start && !abort) begin
        sf_q      <= cfg_sf;
        pre_q     <= cfg_pre_len;
        sync_q    <= cfg_sync_word;
        pre_cnt   <= '0;
        underflow <= 1'b0;
      end
      if ((state == ST_PAY_I) && !s_axis_tvalid && !abort) underflow <= 1'b1;
      if ((state == ST_PRE_W) && chirp_done && !abort)
        pre_cnt <= pre_last ? '0 : pre_cnt + 1'b1;
      if (strobe) begin
        up_q      <= cur_up;
        quarter_q <= cur_quarter;
        sym_q     <= cur_sym;
      end
      if (strobe && (state == ST_PAY_I)) last_q <= s_axis_tlast;
    end
  end

  assign s_axis_tready = tready;
  assign chirp_start   = strobe;
  assign chirp_up      = strobe ? cur_up      : up_q;
  assign chirp_quarter = strobe ? cur_quarter : quarter_q;
  assign chirp_symbol  = strobe ? cur_sym     : sym_q;
  assign chirp_sf      = sf_q;
  assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_r4w_lora_frame_seq.sv
`timescale 1ns/1ps
module tb_r4w_lora_frame_seq;
  localparam int SW = 12;
  localparam int PW = 8;

  logic          clk;
  logic          rst;
  logic [3:0]    cfg_sf;
  logic [PW-1:0] cfg_pre_len;
  logic [7:0]    cfg_sync_word;
  logic          start;
  logic          abort;
  logic [SW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic          chirp_start;
  logic          chirp_up;
  logic          chirp_quarter;
  logic [SW-1:0] chirp_symbol;
  logic [3:0]    chirp_sf;
  logic          chirp_done;
  logic          busy;
  logic          frame_done;
  logic          underflow;

  r4w_lora_frame_seq #(.SYM_WIDTH(SW), .PRE_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .cfg_sf(cfg_sf), .cfg_pre_len(cfg_pre_len),
    .cfg_sync_word(cfg_sync_word), .start(start), .abort(abort),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .chirp_start(chirp_start), .chirp_up(chirp_up), .chirp_quarter(chirp_quarter),
    .chirp_symbol(chirp_symbol), .chirp_sf(chirp_sf), .chirp_done(chirp_done),
    .busy(busy), .frame_done(frame_done), .underflow(underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed { logic up; logic q; logic [SW-1:0] sym; } cmd_t;
  typedef struct packed { logic [SW-1:0] data; logic last; } beat_t;

  cmd_t  exp_q[$];
  beat_t feed_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    n_strobe = 0;
  int    n_fd = 0;
  int    gen_dly = 2;
  bit    free_strobe = 1'b0;
  logic [3:0] exp_sf = 4'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push_cmd(input logic up, input logic q, input int sym);
    cmd_t c;
    c.up = up; c.q = q; c.sym = SW'(sym);
    exp_q.push_back(c);
  endtask

  task automatic push_beat(input int d, input logic last);
    beat_t b;
    b.data = SW'(d); b.last = last;
    feed_q.push_back(b);
  endtask

  // Reference frame header: preamble, sync words, SFD.
  task automatic push_hdr(input int sf, input int pre, input logic [7:0] sync);
    int m;
    int np;
    m  = (1 << sf) - 1;
    np = (pre == 0) ? 1 : pre;
    for (int i = 0; i < np; i++) push_cmd(1'b1, 1'b0, 0);
    push_cmd(1'b1, 1'b0, (int'(sync[7:4]) * 8) & m);
    push_cmd(1'b1, 1'b0, (int'(sync[3:0]) * 8) & m);
    push_cmd(1'b0, 1'b0, 0);
    push_cmd(1'b0, 1'b0, 0);
    push_cmd(1'b0, 1'b1, 0);
  endtask

  // Command monitor / scoreboard.
  initial begin
    cmd_t e;
    logic done_prev;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (chirp_start) begin
        n_strobe++;
        chk("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("chirp_up", 32'(chirp_up), 32'(e.up));
          chk("chirp_quarter", 32'(chirp_quarter), 32'(e.q));
          chk("chirp_symbol", 32'(chirp_symbol), 32'(e.sym));
          chk("chirp_sf", 32'(chirp_sf), 32'(exp_sf));
        end
        if (free_strobe) free_strobe = 1'b0;
        else chk("done_to_strobe_gap", 32'(done_prev), 32'd1);
      end
      if (frame_done) n_fd++;
      done_prev = chirp_done;
    end
  end

  // Generator model: chirp_done gen_dly cycles after each strobe.
  initial begin
    chirp_done = 1'b0;
    forever begin
      @(negedge clk);
      if (chirp_start) begin
        repeat (gen_dly) @(posedge clk);
        #1 chirp_done = 1'b1;
        @(posedge clk);
        #1 chirp_done = 1'b0;
      end
    end
  end

  // Payload source.
  initial begin
    bit hs;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    forever begin
      @(negedge clk);
      hs = s_axis_tvalid && s_axis_tready;
      @(posedge clk);
      #1;
      if (hs && feed_q.size() != 0) void'(feed_q.pop_front());
      if (feed_q.size() != 0) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = feed_q[0].data;
        s_axis_tlast  = feed_q[0].last;
      end else begin
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
      end
    end
  end

  task automatic do_start(input logic [3:0] sf, input logic [7:0] pre, input logic [7:0] sync);
    @(posedge clk);
    #1;
    cfg_sf = sf; cfg_pre_len = pre; cfg_sync_word = sync;
    start = 1'b1; free_strobe = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_no_strobe_yet", 32'(chirp_start), 32'd0);
    @(negedge clk);
    chk("first_issue", 32'(chirp_start), 32'd1);
  endtask

  task automatic wait_strobes(input int n);
    int got;
    got = 0;
    for (int i = 0; i < 2000 && got < n; i++) begin
      @(negedge clk);
      if (chirp_start) got++;
    end
    chk("wait_strobes", 32'(got), 32'(n));
  endtask

  task automatic wait_frame_done();
    int seen;
    seen = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (frame_done) begin
        seen = 1;
        break;
      end
    end
    chk("frame_done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    int fd0;
    int s0;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_sf = '0; cfg_pre_len = '0; cfg_sync_word = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_chirp_start", 32'(chirp_start), 32'd0);
    chk("rst_tready", 32'(s_axis_tready), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);
    chk("rst_chirp_sf", 32'(chirp_sf), 32'd0);
    chk("rst_chirp_up", 32'(chirp_up), 32'd0);
    chk("rst_chirp_quarter", 32'(chirp_quarter), 32'd0);
    chk("rst_chirp_symbol", 32'(chirp_symbol), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // SF7, preamble 8, sync 0x34, payload 5,100; start pulse while busy
    exp_sf = 4'd7;
    push_hdr(7, 8, 8'h34);
    push_cmd(1'b1, 1'b0, 5);
    push_cmd(1'b1, 1'b0, 100);
    push_beat(5, 1'b0);
    push_beat(100, 1'b1);
    fd0 = n_fd; s0 = n_strobe;
    do_start(4'd7, 8'd8, 8'h34);
    wait_strobes(2);
    @(posedge clk);
    #1;
    cfg_sf = 4'd9; cfg_pre_len = 8'd3; cfg_sync_word = 8'hff; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_frame_done();
    chk("fd_busy_low", 32'(busy), 32'd0);
    chk("hold_symbol", 32'(chirp_symbol), 32'd100);
    chk("hold_up", 32'(chirp_up), 32'd1);
    chk("hold_sf", 32'(chirp_sf), 32'd7);
    repeat (5) @(negedge clk);
    chk("f1_frame_done_count", 32'(n_fd - fd0), 32'd1);
    chk("f1_strobe_count", 32'(n_strobe - s0), 32'd15);
    chk("f1_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // SF5, preamble 0 (one chirp), underflow hold then payload 40 -> 8
    exp_sf = 4'd5;
    push_hdr(5, 0, 8'h34);
    push_cmd(1'b1, 1'b0, 40 & 31);
    fd0 = n_fd; s0 = n_strobe;
    do_start(4'd5, 8'd0, 8'h34);
    begin
      int got;
      got = 0;
      for (int i = 0; i < 500; i++) begin
        @(negedge clk);
        if (s_axis_tready) begin
          got = 1;
          break;
        end
      end
      chk("pay_tready_seen", 32'(got), 32'd1);
    end
    chk("pay_strobe_count_before", 32'(n_strobe - s0), 32'd6);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("uf_hold_start_tready", 32'({chirp_start, s_axis_tready}), 32'b01);
    end
    chk("underflow_set", 32'(underflow), 32'd1);
    @(posedge clk);
    #1 free_strobe = 1'b1;
    push_beat(40, 1'b1);
    wait_frame_done();
    chk("underflow_sticky", 32'(underflow), 32'd1);
    chk("f2_busy_low", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("f2_strobe_count", 32'(n_strobe - s0), 32'd7);
    chk("f2_frame_done_count", 32'(n_fd - fd0), 32'd1);

    // Abort during SFD2 wait; late chirp_done must be ignored
    gen_dly = 10;
    exp_sf = 4'd7;
    push_hdr(7, 2, 8'h12);
    void'(exp_q.pop_back());
    fd0 = n_fd;
    do_start(4'd7, 8'd2, 8'h12);
    chk("underflow_cleared", 32'(underflow), 32'd0);
    wait_strobes(5);
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_tready", 32'(s_axis_tready), 32'd0);
    chk("abort_strobe", 32'(chirp_start), 32'd0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("abort_quiet", 32'({chirp_start, busy}), 32'd0);
    end
    chk("abort_no_frame_done", 32'(n_fd - fd0), 32'd0);
    chk("abort_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // Restart after abort: SF8, preamble 1, sync 0x00, payload 255
    gen_dly = 2;
    exp_sf = 4'd8;
    push_hdr(8, 1, 8'h00);
    push_cmd(1'b1, 1'b0, 255);
    push_beat(255, 1'b1);
    fd0 = n_fd; s0 = n_strobe;
    do_start(4'd8, 8'd1, 8'h00);
    wait_frame_done();
    repeat (5) @(negedge clk);
    chk("f4_strobe_count", 32'(n_strobe - s0), 32'd7);
    chk("f4_frame_done_count", 32'(n_fd - fd0), 32'd1);
    chk("f4_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("f4_busy_low", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
